// File: rtl/product_accumulator.sv
// product_accumulator: sums N_TERMS multiplier products into an ACC_W-bit result over valid/ready handshakes
// Ports: clk/rst (async active-high); start begins an operation from IDLE;
// prod_valid/prod_ready/prod_in take 4-bit products; sum_valid/sum_ready/sum_out
// present the result; busy is high in ACCUM and DONE; overflow is a sticky wrap flag.
module product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             prod_valid,
  input  logic [3:0]       prod_in,
  output logic             prod_ready,
  output logic             busy,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum_out,
  input  logic             sum_ready,
  output logic             overflow
);
  localparam logic [1:0] IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2;
  localparam int CW = N_TERMS > 1 ? $clog2(N_TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_TERMS - 1);
  logic [1:0] state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0] count;
  logic ov;
  logic xfer;
  logic [ACC_W:0] sum_ext;
  assign xfer = prod_valid && state == ACCUM;
  // one extra bit catches the carry out of the accumulator
  assign sum_ext = {1'b0, acc} + {{(ACC_W - 3){1'b0}}, prod_in};
  assign prod_ready = state == ACCUM;
  assign busy = state != IDLE;
  assign sum_valid = state == DONE;
  assign sum_out = acc;
  assign overflow = ov;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      ov <= 1'b0;
    end else if (state == IDLE && start) begin
      state <= ACCUM;
      acc <= '0;
      count <= '0;
      ov <= 1'b0;
    end else if (xfer) begin
      acc <= sum_ext[ACC_W-1:0];
      ov <= ov | sum_ext[ACC_W];
      count <= count == LAST ? '0 : count + CW'(1);
      state <= count == LAST ? DONE : ACCUM;
    end else if ((state == DONE && sum_ready) || state == 2'd3) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: scoreboard bench for product_accumulator at ACC_W=8 and ACC_W=5
module tb_product_accumulator;
  logic clk = 0, rst = 1, start = 0, prod_valid = 0, sum_ready = 0;
  logic [3:0] prod_in = 0;
  logic prod_ready, busy, sum_valid, overflow;
  logic [7:0] sum_out;
  logic prod_ready5, busy5, sum_valid5, overflow5;
  logic [4:0] sum_out5;
  int total = 0, bad = 0;
  typedef struct {int s8; int s5; int o8; int o5;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  product_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(prod_ready), .busy(busy), .sum_valid(sum_valid), .sum_out(sum_out),
    .sum_ready(sum_ready), .overflow(overflow)
  );
  product_accumulator #(.N_TERMS(4), .ACC_W(5)) dut5 (
    .clk(clk), .rst(rst), .start(start), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(prod_ready5), .busy(busy5), .sum_valid(sum_valid5), .sum_out(sum_out5),
    .sum_ready(sum_ready), .overflow(overflow5)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_prod_ready"}, prod_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sum_valid"}, sum_valid, 0);
    check({tag, "_sum_out"}, sum_out, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_sum_out5"}, sum_out5, 0);
    check({tag, "_sum_valid5"}, sum_valid5, 0);
  endtask
  task automatic run_op(input int p0, input int p1, input int p2, input int p3,
                        input int gap, input int hold, input bit glitch);
    int p[4];
    int part, w;
    exp_t e, g;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    part = p0 + p1 + p2 + p3;
    e.s8 = part % 256; e.s5 = part % 32; e.o8 = int'(part >= 256); e.o5 = int'(part >= 32);
    sb.push_back(e);
    start = 1;
    step();
    start = 0;
    check("ready_after_start", prod_ready, 1);
    check("busy_after_start", busy, 1);
    check("acc_cleared", sum_out, 0);
    check("ov_cleared5", overflow5, 0);
    part = 0;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < gap; s++) begin
        prod_valid = 0;
        prod_in = 4'hf;
        step();
        check("stall_acc", sum_out, part);
        check("stall_ready", prod_ready, 1);
      end
      prod_valid = 1;
      prod_in = 4'(p[i]);
      start = glitch && i == 2;
      step();
      start = 0;
      part += p[i];
      if (i < 3) begin
        check("partial_acc", sum_out, part % 256);
        check("no_early_valid", sum_valid, 0);
      end
    end
    prod_valid = 0;
    prod_in = 4'hf;
    w = 0;
    while (!sum_valid && w < 20) begin
      step();
      w++;
    end
    check("latency", w, 0);
    if (sb.size() > 0) begin
      g = sb.pop_front();
      check("sum8", sum_out, g.s8);
      check("ov8", overflow, g.o8);
      check("valid5", sum_valid5, 1);
      check("sum5", sum_out5, g.s5);
      check("ov5", overflow5, g.o5);
    end else check("sb_empty", 1, 0);
    sum_ready = 0;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", sum_valid, 1);
      check("hold_sum", sum_out, e.s8);
      check("hold_ready", prod_ready, 0);
    end
    sum_ready = 1;
    step();
    sum_ready = 0;
    check("idle_valid", sum_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_sum_kept", sum_out, e.s8);
  endtask
  initial begin
    #1;
    check_reset_vals("por");
    step();
    rst = 0;
    step();
    run_op(1, 6, 9, 4, 0, 0, 0);
    run_op(1, 6, 9, 4, 2, 0, 0);
    run_op(1, 6, 9, 4, 0, 5, 0);
    run_op(9, 9, 9, 9, 0, 0, 0);
    run_op(1, 6, 9, 4, 0, 1, 1);
    run_op(15, 15, 15, 15, 1, 0, 0);
    start = 1;
    step();
    start = 0;
    prod_valid = 1;
    prod_in = 9;
    step();
    step();
    prod_valid = 0;
    check("pre_reset_acc", sum_out, 18);
    #2 rst = 1;
    #1 check_reset_vals("midrst");
    step();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_valid_after_rst", sum_valid, 0);
    end
    run_op(2, 2, 2, 2, 0, 0, 0);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
